// File: rtl/tt_um_micro_accum_if.sv
// Pin bundle for the accumulator micro-tile.
// Master drives the command word; slave returns value and flags.
interface tt_um_micro_accum_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] ui_in;
    logic [WIDTH-1:0] uo_out;
    logic [2:0]       uo_flags;

    modport master (
        output ui_in,
        input  uo_out,
        input  uo_flags
    );

    modport slave (
        input  ui_in,
        output uo_out,
        output uo_flags
    );
endinterface

// File: rtl/tt_um_micro_accum.sv
// Strobe-driven accumulator tile with LOAD/ADD/DOUBLE/RECALL and undo stack.
// Define MICRO_SAT_EN to clamp ADD/DOUBLE overflow instead of wrapping.
module tt_um_micro_accum #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input logic clk,
    input logic rst,
    tt_um_micro_accum_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        OP_LOAD   = 2'b00,
        OP_ADD    = 2'b01,
        OP_DBL    = 2'b10,
        OP_RECALL = 2'b11
    } op_t;

    logic [WIDTH-1:0] in_q;
    logic             strb_prev;
    logic [WIDTH-1:0] acc;
    logic             ovf;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] stk [DEPTH];

    logic             fire;
    op_t              op;
    logic [WIDTH-1:0] d_ext;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] arith;
    logic [WIDTH-1:0] top;
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign fire  = in_q[WIDTH-1] & ~strb_prev;
    assign op    = op_t'(in_q[WIDTH-2:WIDTH-3]);
    assign d_ext = {3'b000, in_q[WIDTH-4:0]};
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    assign opnd = (op == OP_DBL) ? acc : d_ext;
    assign sum  = {1'b0, acc} + {1'b0, opnd};

`ifdef MICRO_SAT_EN
    assign arith = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
`else
    assign arith = sum[WIDTH-1:0];
`endif

    assign do_push = fire & (op != OP_RECALL);
    assign do_pop  = fire & (op == OP_RECALL) & ~empty;

    // Top of stack sits at index count-1
    always_comb begin
        top = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i + 1 == int'(count)) top = stk[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_q      <= '0;
            strb_prev <= 1'b0;
            acc       <= '0;
            ovf       <= 1'b0;
            count     <= '0;
        end else begin
            in_q      <= bus.ui_in;
            strb_prev <= in_q[WIDTH-1];
            if (fire) begin
                unique case (op)
                    OP_LOAD: begin
                        acc <= d_ext;
                        ovf <= 1'b0;
                    end
                    OP_ADD, OP_DBL: begin
                        acc <= arith;
                        ovf <= ovf | sum[WIDTH];
                    end
                    OP_RECALL: begin
                        if (!empty) acc <= top;
                    end
                endcase
            end
            if (do_push && !full) begin
                count <= count + CW'(1);
            end else if (do_pop) begin
                count <= count - CW'(1);
            end
        end
    end

    // A push into a full stack shifts out the oldest entry at index 0
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stk[i] <= '0;
        end else if (do_push) begin
            if (full) begin
                for (int i = 0; i < DEPTH - 1; i++) stk[i] <= stk[i+1];
                stk[DEPTH-1] <= acc;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (i == int'(count)) stk[i] <= acc;
                end
            end
        end
    end

    assign bus.uo_out   = acc;
    assign bus.uo_flags = {full, empty, ovf};
endmodule

// File: tb/tb_tt_um_micro_accum.sv
// Directed plus randomized checks of tt_um_micro_accum.
// Reference model: plain integer arithmetic with a queue as the undo stack.
module tb_tt_um_micro_accum;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int MAXV  = (1 << WIDTH) - 1;

    logic clk = 1'b0;
    logic rst;

    tt_um_micro_accum_if #(.WIDTH(WIDTH)) bus ();

    tt_um_micro_accum #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int acc_m;
    int ovf_m;
    int stk_m[$];

    function automatic logic [7:0] exp_flags();
        logic f, e, o;
        f = (stk_m.size() == DEPTH);
        e = (stk_m.size() == 0);
        o = (ovf_m != 0);
        return {5'b0, f, e, o};
    endfunction

    task automatic model_reset();
        acc_m = 0;
        ovf_m = 0;
        stk_m.delete();
    endtask

    task automatic model_push();
        if (stk_m.size() == DEPTH) void'(stk_m.pop_front());
        stk_m.push_back(acc_m);
    endtask

    task automatic model_apply(input int op, input int d);
        int s;
        case (op)
            0: begin
                model_push();
                acc_m = d;
                ovf_m = 0;
            end
            1, 2: begin
                model_push();
                s = acc_m + ((op == 1) ? d : acc_m);
                if (s > MAXV) begin
                    ovf_m = 1;
`ifdef MICRO_SAT_EN
                    acc_m = MAXV;
`else
                    acc_m = s - (MAXV + 1);
`endif
                end else begin
                    acc_m = s;
                end
            end
            default: begin
                if (stk_m.size() > 0) acc_m = stk_m.pop_back();
            end
        endcase
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_out"}, bus.uo_out, 8'(acc_m));
        chk({tag, "_flags"}, {5'b0, bus.uo_flags}, exp_flags());
    endtask

    // Strobe high for hold cycles, then one low cycle, then check.
    task automatic cmd(input int op, input int d, input int hold);
        bus.ui_in = 8'(128 | (op << 5) | d);
        @(negedge clk);
        chk("latency_old", bus.uo_out, 8'(acc_m));
        repeat (hold - 1) @(negedge clk);
        bus.ui_in = 8'h00;
        @(negedge clk);
        model_apply(op, d);
        chk_model("cmd");
    endtask

    initial begin
        rst = 1'b1;
        bus.ui_in = 8'h00;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_out", bus.uo_out, 8'h00);
        chk("reset_flags", {5'b0, bus.uo_flags}, 8'h02);

        bus.ui_in = 8'h85;
        @(negedge clk);
        bus.ui_in = 8'h00;
        @(negedge clk);
        chk("rst_hold_out", bus.uo_out, 8'h00);
        chk("rst_hold_flags", {5'b0, bus.uo_flags}, 8'h02);
        rst = 1'b0;
        @(negedge clk);

        cmd(0, 5, 1);
        chk("plan_load5", bus.uo_out, 8'd5);
        cmd(1, 3, 1);
        chk("plan_add3", bus.uo_out, 8'd8);
        cmd(2, 0, 1);
        chk("plan_dbl", bus.uo_out, 8'd16);
        cmd(3, 0, 1);
        chk("plan_rcl1", bus.uo_out, 8'd8);
        cmd(3, 0, 1);
        chk("plan_rcl2", bus.uo_out, 8'd5);

        cmd(0, 0, 1);
        cmd(1, 1, 10);
        chk("plan_held", bus.uo_out, 8'd1);

        cmd(0, 31, 1);
        cmd(2, 0, 1);
        chk("plan_d62", bus.uo_out, 8'd62);
        cmd(2, 0, 1);
        chk("plan_d124", bus.uo_out, 8'd124);
        cmd(2, 0, 1);
        chk("plan_d248", bus.uo_out, 8'd248);
        cmd(2, 0, 1);
`ifdef MICRO_SAT_EN
        chk("plan_d_ovf", bus.uo_out, 8'd255);
`else
        chk("plan_d_ovf", bus.uo_out, 8'd240);
`endif
        chk("plan_ovf_set", {7'b0, bus.uo_flags[0]}, 8'd1);
        cmd(2, 0, 1);
        chk("plan_ovf_sticky", {7'b0, bus.uo_flags[0]}, 8'd1);
        cmd(0, 1, 1);
        chk("plan_ovf_clr", {7'b0, bus.uo_flags[0]}, 8'd0);

        for (int i = 0; i < 5; i++) cmd(1, 1, 1);
        chk("plan_full", {7'b0, bus.uo_flags[2]}, 8'd1);
        cmd(3, 0, 1);
        chk("plan_pop5", bus.uo_out, 8'd5);
        cmd(3, 0, 1);
        chk("plan_pop4", bus.uo_out, 8'd4);
        cmd(3, 0, 1);
        chk("plan_pop3", bus.uo_out, 8'd3);
        cmd(3, 0, 1);
        chk("plan_pop2", bus.uo_out, 8'd2);
        cmd(3, 0, 1);
        chk("plan_pop_empty", bus.uo_out, 8'd2);
        chk("plan_empty", {7'b0, bus.uo_flags[1]}, 8'd1);

        cmd(0, 9, 1);
        bus.ui_in = 8'hA1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        model_reset();
        chk("midrst_out", bus.uo_out, 8'h00);
        chk("midrst_flags", {5'b0, bus.uo_flags}, 8'h02);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        bus.ui_in = 8'h00;
        @(negedge clk);
        model_apply(1, 1);
        chk_model("midrst_after");
        chk("midrst_one_add", bus.uo_out, 8'd1);
        chk("midrst_flags2", {5'b0, bus.uo_flags}, 8'h00);

        for (int i = 0; i < 300; i++) begin
            int op, d, hold;
            op   = int'($urandom_range(0, 3));
            d    = int'($urandom_range(0, 31));
            hold = int'($urandom_range(1, 3));
            cmd(op, d, hold);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
